fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
// Sequences instruction fetch around the ProgramCounter register. Each cycle it decides whether
// the PC advances, is redirected or holds. It drives pc_load/pc_in and issues instruction-memory
// requests over a valid/ready handshake, with at most one request outstanding.
// Fetched instructions go to decode over a valid/ready interface with one-entry skid buffering.
// Trap and branch redirects are handled mid-fetch; any stale in-flight response is discarded.
// PARAMETERS
// RESET_VECTOR  32'h01000000  PC after reset; must match the PC register reset value
// TRAP_VECTOR   32'h01000100  PC loaded on trap
// PORTS
// clock            in   1   system clock, all logic on posedge
// rst              in   1   synchronous reset, active-high
// pc_cur           in   32  current PC from ProgramCounter.pc_out
// pc_load          out  1   load strobe to ProgramCounter
// pc_in            out  32  next PC to ProgramCounter
// imem_req_valid   out  1   fetch request valid
// imem_req_ready   in   1   memory accepts request
// imem_addr        out  32  fetch address (= pc_cur)
// imem_rsp_valid   in   1   response valid, one cycle, cannot be backpressured
// imem_rsp_data    in   32  instruction word
// if_valid         out  1   instruction valid to decode (registered)
// if_instr         out  32  instruction to decode
// if_pc            out  32  PC of if_instr
// id_ready         in   1   decode accepts; transfer when if_valid & id_ready
// redirect         in   1   branch/jump taken, single-cycle pulse
// redirect_target  in   32  redirect destination; bits [1:0] forced to 0
// trap             in   1   trap request, single-cycle pulse; priority over redirect
// BEHAVIOUR
// - States: IDLE, REQ, WAIT, HOLD, DROP. rst (sync) -> IDLE. All outputs 0 in reset and in IDLE.
// - IDLE: one cycle, then REQ. imem_rsp_valid is ignored in IDLE.
// - REQ: imem_req_valid=1, imem_addr=pc_cur. On valid&ready, latch req_pc=pc_cur -> WAIT.
// - WAIT: on imem_rsp_valid, accept response: pc_load=1, pc_in=req_pc+4 (mod 2^32, wraps).
//   If the output register is empty or drains this cycle (if_valid&id_ready): load
//   if_instr/if_pc next cycle -> REQ. Else store in the pending register -> HOLD.
// - HOLD: no requests. When if_valid&id_ready, pending moves to the output register
//   next cycle -> REQ.
// - Output register: if_valid set on load, cleared on transfer when there is no refill.
//   A transfer and a refill in the same cycle leaves if_valid=1 with the new data.
// - Redirect/trap (any state except IDLE): pc_load=1, pc_in = trap ? TRAP_VECTOR : {redirect_target[31:2],2'b00}.
//   if_valid and pending are cleared next cycle.
//   - Next state is DROP if a request is outstanding: in WAIT with no response this cycle,
//     or a REQ handshake this cycle. Otherwise the next state is REQ.
//   - A response arriving in the same cycle as the redirect is discarded: no PC advance
//     from it and no output load.
// - DROP: no requests. The next imem_rsp_valid is discarded -> REQ.
//   A redirect in DROP reloads the PC and stays in DROP.
// - Redirect wins over a simultaneous sequential pc_load; trap wins over redirect.
// - pc_load is combinational from state and inputs. pc_in is don't-care when pc_load=0
//   but is driven 0.
// - Latency: fetch to if_valid is 1 cycle after imem_rsp_valid. Zero-wait memory gives
//   one instruction per 2 cycles (REQ, WAIT).
// - rst mid-operation: all state, pending and if_valid cleared. Any outstanding response
//   is ignored (IDLE ignores rsp).
// TESTING
// - Reset, req_ready=1, rsp 1 cycle later: addr 0x01000000, then 0x01000004 and 0x01000008;
//   if_pc matches each addr; pc_in=addr+4.
// - id_ready=0 for 6 cycles: first instr held in the output register, second in pending,
//   no third request. Release -> both delivered in order, none lost.
// - Redirect to 0x01000203 while in WAIT: pc_in=0x01000200. The next response is dropped;
//   if_valid stays 0 until the fetch from 0x01000200 returns.
// - trap and redirect in the same cycle: pc_in=TRAP_VECTOR; the next if_pc is 0x01000100.
// - req_pc=0xFFFFFFFC: pc_in wraps to 0x00000000.
// - rst asserted in WAIT with a response the next cycle: response ignored; first fetch after
//   IDLE is RESET_VECTOR.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: steers the ProgramCounter, issues one-at-a-time imem requests,
// and buffers fetched words toward decode, flushing cleanly on trap/redirect.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0100_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0100_0100
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic        pc_load,
  output logic [31:0] pc_in,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        trap
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] req_pc;
  logic [31:0] pend_instr;
  logic [31:0] pend_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        flush;
  logic        req_fire;
  logic        rsp_take;
  logic        drain;
  logic        out_fill_rsp;
  logic        out_fill_pend;
  logic        pend_fill;
  logic [31:0] redirect_pc;

  // Trap/redirect take effect in every state but IDLE, and never while reset is asserted.
  assign flush       = !rst && (state != S_IDLE) && (trap || redirect);
  assign redirect_pc = redirect_target & ~32'h3;
  assign req_fire    = (state == S_REQ) && imem_req_ready;
  assign rsp_take    = (state == S_WAIT) && imem_rsp_valid && !flush;
  assign drain       = out_valid && id_ready;

  assign out_fill_rsp  = rsp_take && (!out_valid || drain);
  assign pend_fill     = rsp_take && out_valid && !drain;
  assign out_fill_pend = (state == S_HOLD) && drain && !flush;

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (req_fire) begin
          state_nxt = flush ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          state_nxt = (!out_valid || drain) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (flush || drain) begin
          state_nxt = S_REQ;
        end
      end
      // A redirect here only reloads the PC; DROP is left once the stale response retires,
      // including when it retires in the same cycle as the redirect.
      S_DROP: begin
        if (imem_rsp_valid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: trap beats redirect, and both beat the sequential advance.
  always_comb begin
    pc_load        = 1'b0;
    pc_in          = '0;
    imem_req_valid = 1'b0;
    imem_addr      = '0;
    if (!rst) begin
      if (state == S_REQ) begin
        imem_req_valid = 1'b1;
        imem_addr      = pc_cur;
      end
      if (flush) begin
        pc_load = 1'b1;
        pc_in   = trap ? TRAP_VECTOR : redirect_pc;
      end else if (rsp_take) begin
        pc_load = 1'b1;
        pc_in   = req_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      req_pc <= RESET_VECTOR;
    end else if (req_fire) begin
      req_pc <= pc_cur;
    end
  end

  // Decode-facing register: refill and transfer in one cycle keeps if_valid high.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (out_fill_rsp) begin
      out_valid <= 1'b1;
      out_instr <= imem_rsp_data;
      out_pc    <= req_pc;
    end else if (out_fill_pend) begin
      out_valid <= 1'b1;
      out_instr <= pend_instr;
      out_pc    <= pend_pc;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: the pending payload has no reset; its validity is carried by being in HOLD.
  always_ff @(posedge clock) begin
    if (pend_fill) begin
      pend_instr <= imem_rsp_data;
      pend_pc    <= req_pc;
    end
  end

  assign if_valid = out_valid;
  assign if_instr = out_instr;
  assign if_pc    = out_pc;

endmodule
